// File: rtl/add_pkg.sv
//------------------------------------------------------------------------------
// Module   : add_pkg
// Brief    : Constants and types shared by the adder stage and its window
//            accumulator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package add_pkg;

    localparam int SUM_W_DEF = 5;
    localparam int DEPTH_DEF = 4;

    typedef logic [SUM_W_DEF-1:0] sum_t;

    // FILL until the window holds DEPTH samples, then STEADY until clr/rst
    typedef enum logic [0:0] {
        PH_FILL   = 1'b0,
        PH_STEADY = 1'b1
    } phase_t;

endpackage

`default_nettype wire

// File: rtl/sum_window_acc_if.sv
//------------------------------------------------------------------------------
// Module   : sum_win_if
// Brief    : Input/output handshakes and status of the sliding-window
//            accumulator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sum_win_if
    import add_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int ACC_W = SUM_W + $clog2(DEPTH)
) (
    input wire logic clk,
    input wire logic rst
);

    logic                     clr;
    logic                     in_valid;
    logic [SUM_W-1:0]         in_sum;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [ACC_W-1:0]         out_acc;
    logic [SUM_W-1:0]         out_avg;
    logic                     out_full;
    logic [$clog2(DEPTH):0]   fill;

    modport slave (
        input  clr, in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_acc, out_avg, out_full, fill
    );

    modport master (
        input  clk, rst, in_ready, out_valid, out_acc, out_avg, out_full, fill,
        output clr, in_valid, in_sum, out_ready
    );

endinterface

`default_nettype wire

// File: rtl/sum_window_buf.sv
//------------------------------------------------------------------------------
// Module   : sum_window_buf
// Brief    : DEPTH x SUM_W circular sample store; async read at the write
//            address returns the oldest entry once the window is full.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sum_window_buf #(
    parameter int SUM_W = 5,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             we,
    input  wire logic [PTR_W-1:0] waddr,
    input  wire logic [SUM_W-1:0] wdata,
    output logic      [SUM_W-1:0] rdata
);

    logic [SUM_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[waddr];

endmodule

`default_nettype wire

// File: rtl/sum_window_acc.sv
//------------------------------------------------------------------------------
// Module   : sum_window_acc
// Brief    : Sliding-window running total and floor average of adder sums,
//            valid/ready on both sides with a one-deep output register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sum_window_acc
    import add_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int ACC_W = SUM_W + $clog2(DEPTH)
) (
    input  wire logic clk,
    input  wire logic rst,
    sum_win_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_acc_q,   out_acc_d;
    logic [SUM_W-1:0] out_avg_q,   out_avg_d;
    logic             out_full_q,  out_full_d;

    logic             in_ready;
    logic             accept;
    logic [SUM_W-1:0] oldest;
    phase_t           phase;

    assign phase    = (count_q == CNT_W'(DEPTH)) ? PH_STEADY : PH_FILL;
    assign in_ready = !bus.clr && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    sum_window_buf #(
        .SUM_W (SUM_W),
        .DEPTH (DEPTH)
    ) u_win_buf (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr_q),
        .wdata (bus.in_sum),
        .rdata (oldest)
    );

    always_comb begin
        acc_d       = acc_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_avg_d   = out_avg_q;
        out_full_d  = out_full_q;

        if (bus.clr) begin
            // Buffer contents are left stale; they are only read in STEADY
            acc_d       = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            case (phase)
                PH_STEADY: begin
                    acc_d = acc_q + ACC_W'(bus.in_sum) - ACC_W'(oldest);
                end
                default: begin
                    acc_d   = acc_q + ACC_W'(bus.in_sum);
                    count_d = count_q + CNT_W'(1);
                end
            endcase
            wr_ptr_d    = wr_ptr_q + PTR_W'(1);
            out_valid_d = 1'b1;
            out_acc_d   = acc_d;
            out_avg_d   = SUM_W'(acc_d >> PTR_W);
            out_full_d  = (count_d == CNT_W'(DEPTH));
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_avg_q   <= '0;
            out_full_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_avg_q   <= out_avg_d;
            out_full_q  <= out_full_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_avg   = out_avg_q;
    assign bus.out_full  = out_full_q;
    assign bus.fill      = count_q;

endmodule

`default_nettype wire

// File: tb/tb_sum_window_acc.sv
//------------------------------------------------------------------------------
// Module   : tb_sum_window_acc
// Brief    : Directed vector table plus randomized run against a window model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sum_window_acc;
    import add_pkg::*;

    localparam int SUM_W = 5;
    localparam int DEPTH = 4;
    localparam int ACC_W = 7;

    typedef struct {
        int rst;
        int clr;
        int iv;
        int sum;
        int ordy;
        int chk_rdy;
        int e_rdy;
        int e_valid;
        int e_acc;
        int e_avg;
        int e_full;
        int e_fill;
    } vec_t;

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;

    sum_win_if #(.SUM_W(SUM_W), .DEPTH(DEPTH), .ACC_W(ACC_W)) bus (.clk(clk), .rst(rst));

    sum_window_acc #(.SUM_W(SUM_W), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int r, input int c, input int iv, input int s, input int ordy);
        rst          = r[0];
        bus.clr      = c[0];
        bus.in_valid = iv[0];
        bus.in_sum   = SUM_W'(s);
        bus.out_ready = ordy[0];
    endtask

    vec_t vecs[$];

    // Reference model: the window as a plain queue of accepted samples
    int   win[$];
    bit   m_valid;
    int   m_acc;
    int   m_avg;
    bit   m_full;

    function automatic int win_sum();
        int s = 0;
        foreach (win[i]) s += win[i];
        return s;
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        drive(1, 0, 0, 0, 1);

        //                rst clr iv sum ordy chkR eR  eV acc avg full fill
        vecs.push_back('{1, 0, 1,  7, 1, 0, 0, 0,   0,  0, 0, 0});
        vecs.push_back('{1, 0, 1,  7, 1, 0, 0, 0,   0,  0, 0, 0});
        vecs.push_back('{0, 0, 0,  0, 1, 1, 1, 0,   0,  0, 0, 0});
        vecs.push_back('{0, 0, 1,  3, 1, 1, 1, 1,   3,  0, 0, 1});
        vecs.push_back('{0, 0, 1,  5, 1, 1, 1, 1,   8,  2, 0, 2});
        vecs.push_back('{0, 0, 1,  7, 1, 1, 1, 1,  15,  3, 0, 3});
        vecs.push_back('{0, 0, 1,  9, 1, 1, 1, 1,  24,  6, 1, 4});
        vecs.push_back('{0, 0, 1, 11, 1, 1, 1, 1,  32,  8, 1, 4});
        vecs.push_back('{0, 0, 1, 31, 1, 1, 1, 1,  58, 14, 1, 4});
        vecs.push_back('{0, 1, 0,  0, 1, 1, 0, 0,  58, 14, 1, 0});
        vecs.push_back('{0, 0, 1, 31, 1, 1, 1, 1,  31,  7, 0, 1});
        vecs.push_back('{0, 0, 1, 31, 1, 1, 1, 1,  62, 15, 0, 2});
        vecs.push_back('{0, 0, 1, 31, 1, 1, 1, 1,  93, 23, 0, 3});
        vecs.push_back('{0, 0, 1, 31, 1, 1, 1, 1, 124, 31, 1, 4});
        vecs.push_back('{0, 1, 0,  0, 1, 1, 0, 0, 124, 31, 1, 0});
        vecs.push_back('{0, 0, 1, 10, 0, 1, 1, 1,  10,  2, 0, 1});
        vecs.push_back('{0, 0, 1, 20, 0, 1, 0, 1,  10,  2, 0, 1});
        vecs.push_back('{0, 0, 1, 20, 0, 1, 0, 1,  10,  2, 0, 1});
        vecs.push_back('{0, 0, 1, 20, 0, 1, 0, 1,  10,  2, 0, 1});
        vecs.push_back('{0, 0, 1, 20, 1, 1, 1, 1,  30,  7, 0, 2});
        vecs.push_back('{0, 0, 1,  9, 1, 1, 1, 1,  39,  9, 0, 3});
        vecs.push_back('{0, 1, 1,  9, 1, 1, 0, 0,  39,  9, 0, 0});
        vecs.push_back('{0, 0, 1,  4, 1, 1, 1, 1,   4,  1, 0, 1});
        vecs.push_back('{0, 0, 0,  0, 1, 1, 1, 0,   4,  1, 0, 1});

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].clr, vecs[i].iv, vecs[i].sum, vecs[i].ordy);
            #3;
            if (vecs[i].chk_rdy != 0) chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), vecs[i].e_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), vecs[i].e_valid);
            chk($sformatf("vec%0d out_acc", i),   32'(bus.out_acc),   vecs[i].e_acc);
            chk($sformatf("vec%0d out_avg", i),   32'(bus.out_avg),   vecs[i].e_avg);
            chk($sformatf("vec%0d out_full", i),  32'(bus.out_full),  vecs[i].e_full);
            chk($sformatf("vec%0d fill", i),      32'(bus.fill),      vecs[i].e_fill);
        end

        // Hand-written: drain with a simultaneous accept keeps out_valid high
        drive(0, 1, 0, 0, 1);
        @(posedge clk); #1;
        drive(0, 0, 1, 2, 0);
        @(posedge clk); #1;
        drive(0, 0, 1, 6, 1);
        #3;
        chk("drain_accept in_ready", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        chk("drain_accept out_valid", 32'(bus.out_valid), 1);
        chk("drain_accept out_acc", 32'(bus.out_acc), 8);
        // rst with a pending output discards it
        drive(0, 0, 1, 5, 0);
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("rst_pending out_valid", 32'(bus.out_valid), 0);
        chk("rst_pending out_acc", 32'(bus.out_acc), 0);
        chk("rst_pending fill", 32'(bus.fill), 0);

        // Randomized run against the model, starting from reset
        win.delete();
        m_valid = 0; m_acc = 0; m_avg = 0; m_full = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            int  r, c, iv, s, ordy;
            bit  e_rdy, acc_ok;
            r    = ($urandom_range(99) < 2) ? 1 : 0;
            c    = ($urandom_range(99) < 5) ? 1 : 0;
            iv   = ($urandom_range(99) < 75) ? 1 : 0;
            s    = $urandom_range(31);
            ordy = ($urandom_range(99) < 65) ? 1 : 0;
            drive(r, c, iv, s, ordy);
            #3;
            e_rdy  = (c == 0) && (!m_valid || ordy != 0);
            acc_ok = (iv != 0) && e_rdy;
            if (r == 0) chk("rand in_ready", 32'(bus.in_ready), 32'(e_rdy));
            @(posedge clk);
            #1;
            if (r != 0) begin
                win.delete();
                m_valid = 0; m_acc = 0; m_avg = 0; m_full = 0;
            end else if (c != 0) begin
                win.delete();
                m_valid = 0;
            end else if (acc_ok) begin
                win.push_back(s);
                if (win.size() > DEPTH) void'(win.pop_front());
                m_acc   = win_sum();
                m_avg   = m_acc / DEPTH;
                m_full  = (win.size() == DEPTH);
                m_valid = 1;
            end else if (ordy != 0) begin
                m_valid = 0;
            end
            chk("rand out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("rand out_acc",   32'(bus.out_acc),   m_acc);
            chk("rand out_avg",   32'(bus.out_avg),   m_avg);
            chk("rand out_full",  32'(bus.out_full),  32'(m_full));
            chk("rand fill",      32'(bus.fill),      win.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
